id_exe_reg: RTL

Pipeline register between Instruction Decode and Execute of the 5-stage ARM pipeline. Captures decoded control and operand values each cycle and presents them to the EXE stage, where Val_Rn_EXE and Val_Rm_EXE enter the forwarding muxes. Supports freeze (hazard or memory stall), flush (branch taken in EXE) and a valid bit. Two saturating event counters support pipeline debug.

---
 rtl/arm_pipe_pkg.sv | 29 ++
 rtl/id_exe_reg_sat_counter.sv | 24 ++
 rtl/id_exe_reg.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/arm_pipe_pkg.sv
// Shared definitions for the 5-stage ARM pipeline: datapath widths,
// ALU command encodings and the ID/EXE control bundle.
package arm_pipe_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 4;

  // ALU commands; several mnemonics share an encoding (CMP/SUB, TST/AND, LDR/STR/ADD)
  localparam logic [3:0] EXE_NOP = 4'b0000;
  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;
  localparam logic [3:0] EXE_MVN = 4'b1001;

  typedef struct packed {
    logic       WB_EN;
    logic       MEM_R_EN;
    logic       MEM_W_EN;
    logic       B;
    logic       S;
    logic [3:0] EXE_CMD;
  } id_exe_ctrl_t;

endpackage

// File: rtl/id_exe_reg_sat_counter.sv
// Saturating up-counter with synchronous clear and hold; never wraps.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         hold,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (clear) begin
      count_reg <= '0;
    end else if (!hold && inc && (count_reg != {W{1'b1}})) begin
      count_reg <= count_reg + {{(W-1){1'b0}}, 1'b1};
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/id_exe_reg.sv
// ID/EXE pipeline register with freeze (outranks flush), flush-to-bubble,
// valid bit and saturating bubble/flush event counters.
module id_exe_reg #(
  parameter int DATA_W = arm_pipe_pkg::DATA_W,
  parameter int REG_W  = arm_pipe_pkg::REG_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              flush,
  input  logic              valid_ID,
  input  logic              WB_EN_ID,
  input  logic              MEM_R_EN_ID,
  input  logic              MEM_W_EN_ID,
  input  logic              B_ID,
  input  logic              S_ID,
  input  logic              imm_ID,
  input  logic [3:0]        EXE_CMD_ID,
  input  logic [DATA_W-1:0] PC_ID,
  input  logic [DATA_W-1:0] Val_Rn_ID,
  input  logic [DATA_W-1:0] Val_Rm_ID,
  input  logic [11:0]       Shift_operand_ID,
  input  logic [23:0]       Signed_imm_24_ID,
  input  logic [REG_W-1:0]  Dest_ID,
  input  logic [REG_W-1:0]  src1_ID,
  input  logic [REG_W-1:0]  src2_ID,
  input  logic [3:0]        SR_ID,
  output logic              valid_EXE,
  output logic              WB_EN_EXE,
  output logic              MEM_R_EN_EXE,
  output logic              MEM_W_EN_EXE,
  output logic              B_EXE,
  output logic              S_EXE,
  output logic              imm_EXE,
  output logic [3:0]        EXE_CMD_EXE,
  output logic [DATA_W-1:0] PC_EXE,
  output logic [DATA_W-1:0] Val_Rn_EXE,
  output logic [DATA_W-1:0] Val_Rm_EXE,
  output logic [11:0]       Shift_operand_EXE,
  output logic [23:0]       Signed_imm_24_EXE,
  output logic [REG_W-1:0]  Dest_EXE,
  output logic [REG_W-1:0]  src1_EXE,
  output logic [REG_W-1:0]  src2_EXE,
  output logic [3:0]        SR_EXE,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  import arm_pipe_pkg::*;

  id_exe_ctrl_t      ctrl_reg, ctrl_next;
  logic              valid_reg;
  logic              imm_reg;
  logic [DATA_W-1:0] pc_reg, val_rn_reg, val_rm_reg;
  logic [11:0]       shift_operand_reg;
  logic [23:0]       signed_imm_24_reg;
  logic [REG_W-1:0]  dest_reg, src1_reg, src2_reg;
  logic [3:0]        sr_reg;

  // An invalid ID slot must not write back, touch memory, branch or set flags.
  always_comb begin
    ctrl_next          = '0;
    ctrl_next.WB_EN    = WB_EN_ID    & valid_ID;
    ctrl_next.MEM_R_EN = MEM_R_EN_ID & valid_ID;
    ctrl_next.MEM_W_EN = MEM_W_EN_ID & valid_ID;
    ctrl_next.B        = B_ID        & valid_ID;
    ctrl_next.S        = S_ID        & valid_ID;
    ctrl_next.EXE_CMD  = EXE_CMD_ID;
  end

  always_ff @(posedge clk) begin
    if (rst || (!freeze && flush)) begin
      ctrl_reg          <= '0;
      valid_reg         <= 1'b0;
      imm_reg           <= 1'b0;
      pc_reg            <= '0;
      val_rn_reg        <= '0;
      val_rm_reg        <= '0;
      shift_operand_reg <= '0;
      signed_imm_24_reg <= '0;
      dest_reg          <= '0;
      src1_reg          <= '0;
      src2_reg          <= '0;
      sr_reg            <= '0;
    end else if (!freeze) begin
      ctrl_reg          <= ctrl_next;
      valid_reg         <= valid_ID;
      imm_reg           <= imm_ID;
      pc_reg            <= PC_ID;
      val_rn_reg        <= Val_Rn_ID;
      val_rm_reg        <= Val_Rm_ID;
      shift_operand_reg <= Shift_operand_ID;
      signed_imm_24_reg <= Signed_imm_24_ID;
      dest_reg          <= Dest_ID;
      src1_reg          <= src1_ID;
      src2_reg          <= src2_ID;
      sr_reg            <= SR_ID;
    end
  end

  assign valid_EXE         = valid_reg;
  assign WB_EN_EXE         = ctrl_reg.WB_EN;
  assign MEM_R_EN_EXE      = ctrl_reg.MEM_R_EN;
  assign MEM_W_EN_EXE      = ctrl_reg.MEM_W_EN;
  assign B_EXE             = ctrl_reg.B;
  assign S_EXE             = ctrl_reg.S;
  assign EXE_CMD_EXE       = ctrl_reg.EXE_CMD;
  assign imm_EXE           = imm_reg;
  assign PC_EXE            = pc_reg;
  assign Val_Rn_EXE        = val_rn_reg;
  assign Val_Rm_EXE        = val_rm_reg;
  assign Shift_operand_EXE = shift_operand_reg;
  assign Signed_imm_24_EXE = signed_imm_24_reg;
  assign Dest_EXE          = dest_reg;
  assign src1_EXE          = src1_reg;
  assign src2_EXE          = src2_reg;
  assign SR_EXE            = sr_reg;

  // Index 0 counts bubbles (flush or invalid ID), index 1 counts flushes.
  logic [1:0]       cnt_inc;
  logic [CNT_W-1:0] cnt_val [2];

  assign cnt_inc[0] = flush | ~valid_ID;
  assign cnt_inc[1] = flush;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      sat_counter #(.W(CNT_W)) u_cnt (
        .clk   (clk),
        .clear (rst),
        .hold  (freeze),
        .inc   (cnt_inc[gi]),
        .count (cnt_val[gi])
      );
    end
  endgenerate

  assign bubble_cnt = cnt_val[0];
  assign flush_cnt  = cnt_val[1];

endmodule
